// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NUM_REQ requesters,
// with bounded burst locking and registered read-data return.
module data_memory_arbiter #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned MAX_LOCK  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0]             we_i,
    input  logic [NUM_REQ-1:0]             lock_i,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   addr_i,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]             ack_o,
    output logic [NUM_REQ-1:0]             rvalid_o,
    output logic [WORD_SIZE-1:0]           rdata_o,
    output logic                           busy_o,
    output logic [ADDR_SIZE-1:0]           mem_addr,
    output logic [WORD_SIZE-1:0]           mem_data_in,
    output logic                           mem_en_write,
    input  logic [WORD_SIZE-1:0]           mem_data_out
);

    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned LW = $clog2(MAX_LOCK) + 1;

    typedef logic [GW-1:0] idx_t;
    typedef logic [LW-1:0] cnt_t;
    typedef enum logic {ARB, ACCESS} state_t;

    state_t state, state_next;
    idx_t   grant, grant_next;
    idx_t   rr_ptr, rr_next;
    cnt_t   lock_cnt, lock_next;

    idx_t             pick;
    idx_t             idx;
    logic             found;
    logic             active;
    logic [NUM_REQ-1:0] rd_hit;

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = idx_t'((32'(rr_ptr) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_next   = state;
        grant_next   = grant;
        rr_next      = rr_ptr;
        lock_next    = lock_cnt;
        ack_o        = '0;
        mem_addr     = '0;
        mem_data_in  = '0;
        mem_en_write = 1'b0;
        active       = 1'b0;

        unique case (state)
            ARB: begin
                if (found) begin
                    state_next = ACCESS;
                    grant_next = pick;
                    lock_next  = '0;
                end
            end
            ACCESS: begin
                active       = req_i[grant];
                mem_addr     = addr_i[32'(grant)*ADDR_SIZE +: ADDR_SIZE];
                mem_data_in  = wdata_i[32'(grant)*WORD_SIZE +: WORD_SIZE];
                mem_en_write = rst_n & active & we_i[grant];
                ack_o[grant] = active;
                // A dropped request releases the grant as if unlocked.
                if (active && lock_i[grant] && (lock_cnt < cnt_t'(MAX_LOCK - 1))) begin
                    lock_next = lock_cnt + 1'b1;
                end else begin
                    rr_next    = (grant == idx_t'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    lock_next  = '0;
                    grant_next = '0;
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    assign rd_hit = ack_o & ~we_i;
    assign busy_o = (state == ACCESS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB;
            grant    <= '0;
            rr_ptr   <= '0;
            lock_cnt <= '0;
            rdata_o  <= '0;
            rvalid_o <= '0;
        end else begin
            state    <= state_next;
            grant    <= grant_next;
            rr_ptr   <= rr_next;
            lock_cnt <= lock_next;
            rvalid_o <= rd_hit;
            if (|rd_hit) begin
                rdata_o <= mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: reset, single access, contention, locked burst,
// protocol violation, and round-robin wrap on a three-requester instance.
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [1:0]  req, we, lock;
    logic [15:0] addr, wdata;
    logic [1:0]  ack, rvalid;
    logic [7:0]  rdata;
    logic        busy;
    logic [7:0]  mem_addr, mem_data_in, mem_data_out;
    logic        mem_en_write;

    logic [2:0]  r3_req, r3_we, r3_lock;
    logic [23:0] r3_addr, r3_wdata;
    logic [2:0]  r3_ack, r3_rvalid;
    logic [7:0]  r3_rdata;
    logic        r3_busy;
    logic [7:0]  r3_mem_addr, r3_mem_data_in, r3_mem_data_out;
    logic        r3_mem_en_write;

    int checks = 0;
    int errors = 0;

    // Memory model: unwritten locations read back addr ^ 8'hC3.
    bit [7:0] mem [256];
    bit       wr  [256];

    always #5 clk = ~clk;

    assign mem_data_out    = wr[mem_addr] ? mem[mem_addr] : (mem_addr ^ 8'hC3);
    assign r3_mem_data_out = r3_mem_addr ^ 8'h5A;

    always @(posedge clk) begin
        if (mem_en_write) begin
            mem[mem_addr] <= mem_data_in;
            wr[mem_addr]  <= 1'b1;
        end
    end

    data_memory_arbiter #(.WORD_SIZE(8), .ADDR_SIZE(8), .NUM_REQ(2), .MAX_LOCK(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .lock_i(lock),
        .addr_i(addr), .wdata_i(wdata), .ack_o(ack), .rvalid_o(rvalid),
        .rdata_o(rdata), .busy_o(busy), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_en_write(mem_en_write),
        .mem_data_out(mem_data_out)
    );

    data_memory_arbiter #(.WORD_SIZE(8), .ADDR_SIZE(8), .NUM_REQ(3), .MAX_LOCK(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_i(r3_req), .we_i(r3_we), .lock_i(r3_lock),
        .addr_i(r3_addr), .wdata_i(r3_wdata), .ack_o(r3_ack), .rvalid_o(r3_rvalid),
        .rdata_o(r3_rdata), .busy_o(r3_busy), .mem_addr(r3_mem_addr),
        .mem_data_in(r3_mem_data_in), .mem_en_write(r3_mem_en_write),
        .mem_data_out(r3_mem_data_out)
    );

    localparam logic [1:0] T3_ACK [9] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    localparam logic [1:0] T3_RV  [9] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    localparam logic [1:0] T4_ACK [7] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    localparam logic [1:0] T4_RV  [7] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        r3_req = '0; r3_we = '0; r3_lock = '0; r3_addr = '0; r3_wdata = '0;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        idle_inputs();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_ack",    32'(ack),          32'h0);
        chk("rst_rvalid", 32'(rvalid),       32'h0);
        chk("rst_rdata",  32'(rdata),        32'h0);
        chk("rst_busy",   32'(busy),         32'h0);
        chk("rst_en_wr",  32'(mem_en_write), 32'h0);
        step();
        rst_n = 1'b1;

        // Reset lands mid-write: write must be suppressed immediately.
        req = 2'b01; we = 2'b01; addr[7:0] = 8'h33; wdata[7:0] = 8'h77;
        #2;
        chk("t1_c0_ack", 32'(ack), 32'h0);
        step();
        #2;
        chk("t1_c1_ack",   32'(ack),          32'h1);
        chk("t1_c1_en",    32'(mem_en_write), 32'h1);
        chk("t1_c1_addr",  32'(mem_addr),     32'h33);
        chk("t1_c1_wdata", 32'(mem_data_in),  32'h77);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_en",   32'(mem_en_write), 32'h0);
        chk("t1_rst_ack",  32'(ack),          32'h0);
        chk("t1_rst_busy", 32'(busy),         32'h0);
        step();
        rst_n = 1'b1;
        idle_inputs();
        #2;
        chk("t1_rel_ack",    32'(ack),         32'h0);
        chk("t1_rel_rvalid", 32'(rvalid),      32'h0);
        chk("t1_rel_rdata",  32'(rdata),       32'h0);
        chk("t1_rel_busy",   32'(busy),        32'h0);
        chk("t1_rel_maddr",  32'(mem_addr),    32'h0);
        chk("t1_rel_mdata",  32'(mem_data_in), 32'h0);
        chk("t1_no_write",   32'(wr[8'h33]),   32'h0);

        // Single write then read of the same location.
        step();
        req = 2'b01; we = 2'b01; addr[7:0] = 8'h10; wdata[7:0] = 8'hA5;
        #2;
        chk("t2_c0_ack", 32'(ack), 32'h0);
        step();
        #2;
        chk("t2_c1_ack",  32'(ack),          32'h1);
        chk("t2_c1_en",   32'(mem_en_write), 32'h1);
        chk("t2_c1_addr", 32'(mem_addr),     32'h10);
        step();
        we = 2'b00;
        #2;
        chk("t2_c2_ack",    32'(ack),    32'h0);
        chk("t2_c2_rvalid", 32'(rvalid), 32'h0);
        step();
        #2;
        chk("t2_c3_ack",  32'(ack),          32'h1);
        chk("t2_c3_en",   32'(mem_en_write), 32'h0);
        chk("t2_c3_busy", 32'(busy),         32'h1);
        step();
        req = 2'b00;
        #2;
        chk("t2_c4_rvalid", 32'(rvalid), 32'h1);
        chk("t2_c4_rdata",  32'(rdata),  32'hA5);
        chk("t2_c4_ack",    32'(ack),    32'h0);

        // Contention from reset: strict alternation.
        do_reset();
        req = 2'b11; we = 2'b00; addr = {8'h20, 8'h10};
        for (int c = 0; c < 9; c++) begin
            if (c != 0) step();
            #2;
            chk($sformatf("t3_c%0d_ack", c),    32'(ack),    32'(T3_ACK[c]));
            chk($sformatf("t3_c%0d_rvalid", c), 32'(rvalid), 32'(T3_RV[c]));
            if (T3_RV[c] == 2'b01) chk($sformatf("t3_c%0d_rdata", c), 32'(rdata), 32'hA5);
            if (T3_RV[c] == 2'b10) chk($sformatf("t3_c%0d_rdata", c), 32'(rdata), 32'hE2 + 32'h1);
        end
        req = 2'b00;

        // Locked burst by requester 1 with requester 0 waiting.
        do_reset();
        req = 2'b10; we = 2'b00; lock = 2'b10; addr[15:8] = 8'h21;
        #2;
        chk("t4_c0_ack", 32'(ack), 32'h0);
        for (int c = 1; c < 7; c++) begin
            step();
            if (c == 1) begin
                req = 2'b11; addr[7:0] = 8'h10;
            end
            #2;
            chk($sformatf("t4_c%0d_ack", c),    32'(ack),    32'(T4_ACK[c]));
            chk($sformatf("t4_c%0d_rvalid", c), 32'(rvalid), 32'(T4_RV[c]));
            if (T4_RV[c] == 2'b10) chk($sformatf("t4_c%0d_rdata", c), 32'(rdata), 32'hE2);
        end
        step();
        req = 2'b00; lock = 2'b00;
        #2;
        chk("t4_c7_rvalid", 32'(rvalid), 32'h1);
        chk("t4_c7_rdata",  32'(rdata),  32'hA5);

        // Protocol violation: granted requester drops its request.
        do_reset();
        req = 2'b10; we = 2'b10; addr[15:8] = 8'h44; wdata[15:8] = 8'h99;
        #2;
        chk("t5_c0_ack", 32'(ack), 32'h0);
        step();
        req = 2'b00;
        #2;
        chk("t5_c1_ack",  32'(ack),          32'h0);
        chk("t5_c1_en",   32'(mem_en_write), 32'h0);
        chk("t5_c1_busy", 32'(busy),         32'h1);
        step();
        req = 2'b11; we = 2'b00; addr = {8'h20, 8'h10};
        #2;
        chk("t5_c2_busy",   32'(busy),   32'h0);
        chk("t5_c2_rvalid", 32'(rvalid), 32'h0);
        step();
        #2;
        chk("t5_c3_ack",     32'(ack),       32'h1);
        chk("t5_no_write",   32'(wr[8'h44]), 32'h0);
        step();
        req = 2'b00;

        // Three requesters: wrap from rr_ptr=2 back to requester 0.
        r3_req = 3'b010; r3_addr[15:8] = 8'h40;
        #2;
        chk("t6_c0_ack", 32'(r3_ack), 32'h0);
        step();
        #2;
        chk("t6_c1_ack",  32'(r3_ack),      32'h2);
        chk("t6_c1_addr", 32'(r3_mem_addr), 32'h40);
        step();
        r3_req = 3'b011; r3_addr[7:0] = 8'h50;
        #2;
        chk("t6_c2_ack",    32'(r3_ack),    32'h0);
        chk("t6_c2_rvalid", 32'(r3_rvalid), 32'h2);
        chk("t6_c2_rdata",  32'(r3_rdata),  32'h1A);
        step();
        #2;
        chk("t6_c3_ack",  32'(r3_ack),      32'h1);
        chk("t6_c3_addr", 32'(r3_mem_addr), 32'h50);
        step();
        r3_req = 3'b010;
        #2;
        chk("t6_c4_ack",    32'(r3_ack),    32'h0);
        chk("t6_c4_rvalid", 32'(r3_rvalid), 32'h1);
        chk("t6_c4_rdata",  32'(r3_rdata),  32'h0A);
        step();
        #2;
        chk("t6_c5_ack", 32'(r3_ack), 32'h2);
        step();
        r3_req = 3'b000;
        #2;
        chk("t6_c6_rvalid", 32'(r3_rvalid), 32'h2);
        chk("t6_c6_rdata",  32'(r3_rdata),  32'h1A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
